// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 brute-force datapath.
//   sched_state_t : key scheduler FSM states
//   KEY_W         : candidate key width
//   PRINT_LO/HI   : printable byte range used by the tester cores
package arc4_pkg;
   localparam int         KEY_W    = 24;
   localparam logic [7:0] PRINT_LO = 8'h20;
   localparam logic [7:0] PRINT_HI = 8'h7E;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;
endpackage

// File: rtl/idle_pick.sv
// Lowest-index idle core picker.
//   idle     : one bit per core, 1 = core may take a new key
//   grant    : one-hot, lowest set bit of idle (zero when none idle)
//   any_idle : at least one core idle
module idle_pick #(
   parameter int N = 2
) (
   input  logic [N-1:0] idle,
   output logic [N-1:0] grant,
   output logic         any_idle
);
   // x & -x isolates the lowest set bit
   assign grant    = idle & (~idle + N'(1));
   assign any_idle = |idle;
endmodule

// File: rtl/key_sched.sv
// Keyspace scheduler: feeds consecutive candidate keys to NUM_CORES tester
// cores and reports the smallest key whose decryption was printable.
//   clk, rst         : clock, synchronous active-high reset
//   en / rdy         : host start pulse / scheduler idle or finished
//   key, key_valid   : result (smallest valid key) and found flag
//   keys_tested      : verdicts collected in the current or last search
//   core_en/core_key : per-core start pulse and candidate key
//   core_rdy         : per-core idle/finished
//   core_key_valid   : per-core verdict, qualified by core_rdy
module key_sched
   import arc4_pkg::*;
#(
   parameter int               NUM_CORES = 2,
   parameter logic [KEY_W-1:0] KEY_MAX   = 24'hFFFFFF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   output logic                         rdy,
   output logic [KEY_W-1:0]             key,
   output logic                         key_valid,
   output logic [24:0]                  keys_tested,
   output logic [NUM_CORES-1:0]         core_en,
   output logic [KEY_W*NUM_CORES-1:0]   core_key,
   input  logic [NUM_CORES-1:0]         core_rdy,
   input  logic [NUM_CORES-1:0]         core_key_valid
);
   localparam int NP = 8;   // min tree leaves, covers the max core count

   sched_state_t state, state_nx;
   logic [KEY_W:0]                       next_key;
   logic [NUM_CORES-1:0]                 busy, busy_nx, en_q, done, idle, grant;
   logic [NUM_CORES-1:0][KEY_W-1:0]      key_reg;
   logic                                 any_idle, issue, start;
   logic                                 found, found_nx, any_valid;
   logic [KEY_W-1:0]                     best_key, best_nx;
   logic [NP-1:0][KEY_W:0]               lvl;
   logic [3:0]                           cnt;

   assign rdy   = (state == IDLE) || (state == DONE);
   assign start = rdy && en;

   // A core's rdy is still high in the cycle it is started; en_q masks that.
   assign done = busy & core_rdy & ~en_q;
   assign idle = ~(busy & ~done);   // completing cores are reissuable now

   idle_pick #(.N(NUM_CORES)) u_pick (
      .idle     (idle),
      .grant    (grant),
      .any_idle (any_idle)
   );

   assign issue   = (state == RUN) && any_idle && (next_key <= {1'b0, KEY_MAX});
   assign core_en = issue ? grant : '0;
   assign busy_nx = (busy & ~done) | core_en;

   // The key rides combinationally in the start cycle, then from key_reg.
   for (genvar i = 0; i < NUM_CORES; i++) begin : g_key
      assign core_key[KEY_W*i +: KEY_W] = core_en[i] ? next_key[KEY_W-1:0] : key_reg[i];
   end

   // Parallel min over valid completions; MSB set marks an empty leaf.
   always_comb begin
      lvl = '0;
      for (int j = 0; j < NP; j++) lvl[j] = {1'b1, {KEY_W{1'b0}}};
      for (int i = 0; i < NUM_CORES; i++)
         if (done[i] && core_key_valid[i]) lvl[i] = {1'b0, key_reg[i]};
      for (int s = 1; s < NP; s = s * 2)
         for (int j = 0; j < NP; j = j + 2 * s)
            if (lvl[j+s] < lvl[j]) lvl[j] = lvl[j+s];
   end

   assign any_valid = ~lvl[0][KEY_W];
   assign found_nx  = found | any_valid;

   always_comb begin
      best_nx = best_key;
      if (any_valid && (!found || lvl[0][KEY_W-1:0] < best_key))
         best_nx = lvl[0][KEY_W-1:0];
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_CORES; i++) cnt = cnt + 4'(done[i]);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (en) state_nx = RUN;
         RUN:        if (found_nx || (issue && next_key == {1'b0, KEY_MAX}))
                        state_nx = DRAIN;
         DRAIN:      if (busy_nx == '0) state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         next_key    <= '0;
         busy        <= '0;
         en_q        <= '0;
         found       <= 1'b0;
         best_key    <= '0;
         keys_tested <= '0;
         key         <= '0;
         key_valid   <= 1'b0;
         key_reg     <= '0;
      end else begin
         state <= state_nx;
         en_q  <= core_en;
         if (start) begin
            next_key    <= '0;
            busy        <= '0;
            found       <= 1'b0;
            best_key    <= '0;
            keys_tested <= '0;
            key_valid   <= 1'b0;
         end else begin
            busy        <= busy_nx;
            found       <= found_nx;
            best_key    <= best_nx;
            keys_tested <= keys_tested + 25'(cnt);
            if (issue) next_key <= next_key + 25'd1;
            for (int i = 0; i < NUM_CORES; i++)
               if (core_en[i]) key_reg[i] <= next_key[KEY_W-1:0];
            if (state == DRAIN && busy_nx == '0) begin
               key       <= found_nx ? best_nx : '0;
               key_valid <= found_nx;
            end
         end
      end
   end
endmodule

// File: tb/tb_key_sched.sv
// Directed bench for key_sched with behavioural tester cores
// (fixed latency with per-key overrides, verdict valid on target keys).
module tb_key_sched;
   localparam int NC = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en  = 1'b0;
   logic          rdy, key_valid;
   logic [23:0]   key;
   logic [24:0]   keys_tested;
   logic [NC-1:0] core_en, core_rdy, core_key_valid;
   logic [24*NC-1:0] core_key;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   key_sched #(.NUM_CORES(NC), .KEY_MAX(24'h00000F)) dut (
      .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
      .keys_tested(keys_tested), .core_en(core_en), .core_key(core_key),
      .core_rdy(core_rdy), .core_key_valid(core_key_valid)
   );

   // ---- core models ----
   localparam logic [24:0] NONE = 25'h1FFFFFF;
   int          lat = 10;
   logic [24:0] tgt0 = NONE, tgt1 = NONE;
   logic [24:0] sk0 = NONE, sk1 = NONE;
   int          sl0 = 0, sl1 = 0;

   logic        m_rdy [NC];
   logic        m_val [NC];
   logic [23:0] m_key [NC];
   int          m_cnt [NC];

   function automatic int lat_of(input logic [23:0] k);
      if ({1'b0, k} == sk0) return sl0;
      if ({1'b0, k} == sk1) return sl1;
      return lat;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < NC; i++) begin
         if (rst) begin
            m_rdy[i] <= 1'b1; m_val[i] <= 1'b0; m_cnt[i] <= 0; m_key[i] <= '0;
         end else if (core_en[i] && m_rdy[i]) begin
            m_rdy[i] <= 1'b0; m_val[i] <= 1'b0;
            m_key[i] <= core_key[24*i +: 24];
            m_cnt[i] <= lat_of(core_key[24*i +: 24]);
         end else if (!m_rdy[i]) begin
            if (m_cnt[i] <= 1) begin
               m_rdy[i] <= 1'b1;
               m_val[i] <= ({1'b0, m_key[i]} == tgt0) || ({1'b0, m_key[i]} == tgt1);
            end else m_cnt[i] <= m_cnt[i] - 1;
         end
      end
   end

   always_comb
      for (int i = 0; i < NC; i++) begin
         core_rdy[i]       = m_rdy[i];
         core_key_valid[i] = m_val[i];
      end

   // ---- monitors (free-running counters/records, sampled by the sequence) ----
   logic [NC-1:0] rdy_q = '1;
   int          en_pulses = 0, both_fin = 0;
   logic [23:0] last_issued = '0, last_vkey = '0, prev_vkey = '0;
   always @(posedge clk) begin
      logic [NC-1:0] fin_v;
      fin_v = core_rdy & ~rdy_q & core_key_valid;
      rdy_q <= core_rdy;
      if (&fin_v) both_fin <= both_fin + 1;
      for (int i = 0; i < NC; i++) begin
         if (core_en[i]) begin
            en_pulses   <= en_pulses + 1;
            last_issued <= core_key[24*i +: 24];
         end
      end
      if (fin_v[0] ^ fin_v[1]) begin
         prev_vkey <= last_vkey;
         last_vkey <= fin_v[0] ? m_key[0] : m_key[1];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_en();
      @(negedge clk) en = 1'b1;
      @(negedge clk) en = 1'b0;
   endtask

   task automatic wait_rdy(input string tag, input int max);
      int n = 0;
      while (!rdy && n < max) begin @(negedge clk); n++; end
      check(tag, 32'(rdy), 32'd1);
   endtask

   int p0, b0;

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_rdy",       32'(rdy), 1);
      check("rst_key",       32'(key), 0);
      check("rst_key_valid", 32'(key_valid), 0);
      check("rst_tested",    32'(keys_tested), 0);
      check("rst_core_en",   32'(core_en), 0);
      check("rst_core_key",  core_key[31:0], 0);

      // T1 + T5 (en ignored while running)
      lat = 10; tgt0 = 25'h5;
      pulse_en();
      check("t1_busy", 32'(rdy), 0);
      repeat (3) begin pulse_en(); @(negedge clk); end
      wait_rdy("t1_done", 400);
      check("t1_key",       32'(key), 32'h5);
      check("t1_key_valid", 32'(key_valid), 1);
      check("t1_ge6",       32'(keys_tested >= 25'd6), 1);
      check("t1_le16",      32'(keys_tested <= 25'd16), 1);
      check("t1_cores_idle", 32'(core_rdy), 32'h3);

      // T5: restart from DONE
      @(negedge clk) en = 1'b1;
      @(negedge clk) en = 1'b0;
      check("t5_valid_clr",  32'(key_valid), 0);
      check("t5_tested_clr", 32'(keys_tested), 0);
      check("t5_rdy",        32'(rdy), 0);
      check("t5_core_en",    32'(core_en), 32'h1);
      check("t5_core_key0",  32'(core_key[23:0]), 0);
      wait_rdy("t5_done", 400);
      check("t5_key", 32'(key), 32'h5);
      check("t5_key_valid", 32'(key_valid), 1);

      // T2: out-of-order, key 4 finishes first but key 3 wins
      tgt0 = 25'h3; tgt1 = 25'h4;
      sk0 = 25'h3; sl0 = 40; sk1 = 25'h4; sl1 = 5;
      pulse_en();
      wait_rdy("t2_done", 400);
      check("t2_key",       32'(key), 32'h3);
      check("t2_key_valid", 32'(key_valid), 1);
      check("t2_tested",    32'(keys_tested), 6);
      check("t2_first4",    32'(prev_vkey), 32'h4);
      check("t2_then3",     32'(last_vkey), 32'h3);

      // T3: keys 6 and 7 valid in the same cycle
      tgt0 = 25'h6; tgt1 = 25'h7;
      sk0 = 25'h6; sl0 = 11; sk1 = NONE;
      b0 = both_fin;
      pulse_en();
      wait_rdy("t3_done", 400);
      check("t3_simul",     32'(both_fin - b0), 1);
      check("t3_key",       32'(key), 32'h6);
      check("t3_key_valid", 32'(key_valid), 1);

      // T4: exhaustion at KEY_MAX = 15
      tgt0 = NONE; tgt1 = NONE; sk0 = NONE; lat = 3;
      p0 = en_pulses;
      pulse_en();
      wait_rdy("t4_done", 400);
      repeat (3) @(negedge clk);
      check("t4_key_valid", 32'(key_valid), 0);
      check("t4_key",       32'(key), 0);
      check("t4_tested",    32'(keys_tested), 16);
      check("t4_issues",    32'(en_pulses - p0), 16);
      check("t4_last_key",  32'(last_issued), 32'hF);
      check("t4_rdy",       32'(rdy), 1);

      // T6: reset mid-search, in-flight verdict for key 1 must vanish
      lat = 10; tgt0 = 25'h1;
      pulse_en();
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check("t6_rdy",       32'(rdy), 1);
      check("t6_key_valid", 32'(key_valid), 0);
      check("t6_core_en",   32'(core_en), 0);
      check("t6_tested",    32'(keys_tested), 0);
      p0 = en_pulses;
      repeat (40) @(negedge clk);
      check("t6_stale_tested", 32'(keys_tested), 0);
      check("t6_stale_valid",  32'(key_valid), 0);
      check("t6_no_issue",     32'(en_pulses - p0), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
